ysyx_041461_axi_sram_slave: RTL and testbench
=============================================

Name: ysyx_041461_axi_sram_slave

Overview:
Parametrised AXI4 full slave backed by an internal word array, with independent read and write FSMs. Supports FIXED/INCR/WRAP bursts of up to 256 beats, narrow transfers and byte strobes. It replaces the fixed 64-bit slave shell as the simulation and FPGA memory endpoint behind the core's AXI master.

Parameters:
DATA_W, 64, data bus width in bits (32 or 64).
ADDR_W, 32, address width.
ID_W, 4, transaction ID width.
DEPTH, 4096, number of DATA_W words in the array (power of 2).
BASE_ADDR, 32'h8000_0000, byte address of word 0.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
s_awready  out  1  AW ready.
s_awvalid  in  1  AW valid.
s_awid  in  ID_W  write ID.
s_awaddr  in  ADDR_W  write start byte address.
s_awlen  in  8  beats minus 1.
s_awsize  in  3  log2 bytes per beat.
s_awburst  in  2  burst type.
s_wready  out  1  W ready.
s_wvalid  in  1  W valid.
s_wdata  in  DATA_W  write data.
s_wstrb  in  DATA_W/8  byte enables.
s_wlast  in  1  last write beat.
s_bready  in  1  B ready.
s_bvalid  out  1  B valid.
s_bid  out  ID_W  echoed awid.
s_bresp  out  2  write response.
s_arready  out  1  AR ready.
s_arvalid  in  1  AR valid.
s_arid  in  ID_W  read ID.
s_araddr  in  ADDR_W  read start byte address.
s_arlen  in  8  beats minus 1.
s_arsize  in  3  log2 bytes per beat.
s_arburst  in  2  burst type.
s_rready  in  1  R ready.
s_rvalid  out  1  R valid.
s_rid  out  ID_W  echoed arid.
s_rresp  out  2  read response.
s_rdata  out  DATA_W  read data.
s_rlast  out  1  last read beat.

Behaviour:
- Reset:
  - Both FSMs go to IDLE. bvalid, rvalid and rlast are 0; bid, rid, bresp, rresp and rdata are 0.
  - awready and arready are 1 after reset, because they are driven in IDLE.
  - Array contents are not reset.
  - Reset mid-burst drops the transaction; already written beats persist.
- Word index = byte address[LSB +: log2(DEPTH)], with LSB = log2(DATA_W/8), taken after subtracting BASE_ADDR.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, clear the beat counter and the error flag.
  - W_DATA: wready=1. Each W handshake writes the strobed bytes at the current address, then advances the address and counter.
  - Leaving W_DATA: on the beat where counter==len, go to W_RESP. If wlast does not equal (counter==len) on any beat, set the error flag.
  - W_RESP: bvalid=1, bresp=OKAY or SLVERR (error flag); hold until bready, then W_IDLE. Earliest next awready is the cycle after the B handshake.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch the fields.
  - R_DATA: rvalid=1 from the cycle after the AR handshake. rdata is a combinational array read at the current address; rlast = (counter==len).
  - Each R handshake advances the address and counter, so back-to-back beats run one per cycle. The handshake with rlast=1 returns to R_IDLE.
  - rdata, rresp and rlast are held stable while rvalid=1 and rready=0.
- Address generation, identical for both channels:
  - FIXED: address unchanged.
  - INCR: the next address is the current address aligned down to size, plus (1<<size). An unaligned start affects only the first beat.
  - WRAP: same step as INCR, but wraps within the (len+1)<<size aligned window. len must be 1, 3, 7 or 15; any other len gives SLVERR.
  - Reserved burst (2'b11) gives SLVERR.
- size > LSB gives SLVERR. Writes are suppressed for the whole burst; read data is 0. The burst length is still honoured.
- Read and write run concurrently on a 1W/1R array. A same-cycle read and write to the same word returns the old data.

Optional Feature:
AXI_SRAM_RANGE_CHK_EN:
- Defined: any beat whose address lies outside [BASE_ADDR, BASE_ADDR + DEPTH*DATA_W/8) returns DECERR (2'b11). That beat's write is suppressed, and read data is 0 for that beat. DECERR has priority over SLVERR in bresp.
- Undefined: no range check. The index wraps modulo DEPTH and the response is OKAY.

Decomposition:
- Package ysyx_041461_axi_pkg holds:
  - burst constants FIXED=2'b00, INCR=2'b01, WRAP=2'b10;
  - resp constants OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11;
  - FSM state typedefs.
- Sub-module ysyx_041461_axi_addr_gen (combinational next-address from addr/size/len/burst) is instantiated once per channel.

Test Plan:
- Reset: after rst_n deassertion, awready=1, arready=1, bvalid=0, rvalid=0.
- INCR write at 0x8000_0000 (len=3, size=3, data 0x11..0x44, wstrb=0xFF), then INCR read of the same range with rready held 1 -> rdata 0x11,0x22,0x33,0x44 on 4 consecutive cycles, rlast on beat 4, bresp=OKAY, rid/bid echoed.
- WRAP read at 0x8000_0018 (len=3, size=3) -> beat addresses 0x18, 0x00, 0x08, 0x10 within the 32-byte window.
- Narrow write at 0x8000_0003 (size=0, wstrb=0x08, wdata byte3=0xAB) -> only byte 3 of word 0 changes.
- wlast asserted on beat 2 of len=3 -> bresp=SLVERR. Random rready stalls on reads -> rdata held stable during every stall.
- With AXI_SRAM_RANGE_CHK_EN, a read at BASE_ADDR + DEPTH*8 -> rresp=DECERR, rdata=0. Without the macro, the same read returns word 0 with OKAY.

Source files
------------

// File: rtl/ysyx_041461_axi_pkg.sv
`default_nettype none
// ============================================================================
// ysyx_041461_axi_pkg: AXI burst/response constants and slave FSM states | rev 1.0
// ============================================================================
package ysyx_041461_axi_pkg;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  // A burst the slave cannot serve as described: oversize beat,
  // reserved burst type, or a WRAP length other than 2/4/8/16 beats.
  function automatic logic burst_cfg_err(input logic [2:0] size,
                                         input logic [2:0] max_size,
                                         input logic [1:0] burst,
                                         input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == WRAP) &&
               !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    return (size > max_size) || (burst == 2'b11) || bad_wrap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_041461_axi_addr_gen.sv
`default_nettype none
// ============================================================================
// ysyx_041461_axi_addr_gen: combinational next-beat address for FIXED/INCR/WRAP | rev 1.0
// ============================================================================
module ysyx_041461_axi_addr_gen
  import ysyx_041461_axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] size_mask;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_W'(1) << size;
    size_mask = step - ADDR_W'(1);
    incr_addr = (addr & ~size_mask) + step;
    // WRAP window is (len+1) beats; len is restricted to 2^n-1 so the mask is contiguous
    wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);

    next_addr = addr;
    case (burst)
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_041461_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// ysyx_041461_axi_sram_slave: AXI4 slave over a 1W/1R word array, independent
// read/write FSMs. Optional address range check: AXI_SRAM_RANGE_CHK_EN | rev 1.0
// ============================================================================
module ysyx_041461_axi_sram_slave
  import ysyx_041461_axi_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 32,
  parameter int                ID_W      = 4,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                s_awready,
  input  logic                s_awvalid,
  input  logic [ID_W-1:0]     s_awid,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic [7:0]          s_awlen,
  input  logic [2:0]          s_awsize,
  input  logic [1:0]          s_awburst,
  output logic                s_wready,
  input  logic                s_wvalid,
  input  logic [DATA_W-1:0]   s_wdata,
  input  logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_wlast,
  input  logic                s_bready,
  output logic                s_bvalid,
  output logic [ID_W-1:0]     s_bid,
  output logic [1:0]          s_bresp,
  output logic                s_arready,
  input  logic                s_arvalid,
  input  logic [ID_W-1:0]     s_arid,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic [7:0]          s_arlen,
  input  logic [2:0]          s_arsize,
  input  logic [1:0]          s_arburst,
  input  logic                s_rready,
  output logic                s_rvalid,
  output logic [ID_W-1:0]     s_rid,
  output logic [1:0]          s_rresp,
  output logic [DATA_W-1:0]   s_rdata,
  output logic                s_rlast
);

  localparam int         STRB_W   = DATA_W / 8;
  localparam int         LSB      = $clog2(STRB_W);
  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LSB);

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> LSB);
  endfunction

  // ---------------------------------------------------------------- state
  wr_state_e          wr_state_q, wr_state_d;
  logic [ID_W-1:0]    awid_q, awid_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [7:0]         awlen_q, awlen_d;
  logic [2:0]         awsize_q, awsize_d;
  logic [1:0]         awburst_q, awburst_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic               wcfg_err_q, wcfg_err_d;
  logic               wlast_err_q, wlast_err_d;
  logic               wdec_q, wdec_d;

  rd_state_e          rd_state_q, rd_state_d;
  logic [ID_W-1:0]    arid_q, arid_d;
  logic [ADDR_W-1:0]  raddr_q, raddr_d;
  logic [7:0]         arlen_q, arlen_d;
  logic [2:0]         arsize_q, arsize_d;
  logic [1:0]         arburst_q, arburst_d;
  logic [7:0]         rcnt_q, rcnt_d;
  logic               rcfg_err_q, rcfg_err_d;

  logic [ADDR_W-1:0]  waddr_next, raddr_next;
  logic               wr_in_range, rd_in_range;
  logic               wr_final, rd_final;
  logic               mem_we;
  logic [IDX_W-1:0]   wr_idx, rd_idx;

  logic [DATA_W-1:0]  mem [DEPTH];

  assign wr_final = (wcnt_q == awlen_q);
  assign rd_final = (rcnt_q == arlen_q);
  assign wr_idx   = word_idx(waddr_q);
  assign rd_idx   = word_idx(raddr_q);

`ifdef AXI_SRAM_RANGE_CHK_EN
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * STRB_W);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a >= BASE_ADDR) && ({1'b0, a - BASE_ADDR} < SPAN);
  endfunction

  assign wr_in_range = in_range(waddr_q);
  assign rd_in_range = in_range(raddr_q);
`else
  assign wr_in_range = 1'b1;
  assign rd_in_range = 1'b1;
`endif

  ysyx_041461_axi_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr_gen (
    .addr      (waddr_q),
    .size      (awsize_q),
    .len       (awlen_q),
    .burst     (awburst_q),
    .next_addr (waddr_next)
  );

  ysyx_041461_axi_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr_gen (
    .addr      (raddr_q),
    .size      (arsize_q),
    .len       (arlen_q),
    .burst     (arburst_q),
    .next_addr (raddr_next)
  );

  // ---------------------------------------------------------------- write FSM
  always_comb begin
    wr_state_d  = wr_state_q;
    awid_d      = awid_q;
    waddr_d     = waddr_q;
    awlen_d     = awlen_q;
    awsize_d    = awsize_q;
    awburst_d   = awburst_q;
    wcnt_d      = wcnt_q;
    wcfg_err_d  = wcfg_err_q;
    wlast_err_d = wlast_err_q;
    wdec_d      = wdec_q;
    mem_we      = 1'b0;
    s_awready   = 1'b0;
    s_wready    = 1'b0;
    s_bvalid    = 1'b0;

    case (wr_state_q)
      W_IDLE: begin
        s_awready = 1'b1;
        if (s_awvalid) begin
          awid_d      = s_awid;
          waddr_d     = s_awaddr;
          awlen_d     = s_awlen;
          awsize_d    = s_awsize;
          awburst_d   = s_awburst;
          wcnt_d      = 8'd0;
          wcfg_err_d  = burst_cfg_err(s_awsize, MAX_SIZE, s_awburst, s_awlen);
          wlast_err_d = 1'b0;
          wdec_d      = 1'b0;
          wr_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        s_wready = 1'b1;
        if (s_wvalid) begin
          // A malformed burst still consumes every beat but touches no memory
          mem_we  = !wcfg_err_q && wr_in_range;
          waddr_d = waddr_next;
          wcnt_d  = wcnt_q + 8'd1;
          if (s_wlast != wr_final) wlast_err_d = 1'b1;
          if (!wr_in_range)        wdec_d      = 1'b1;
          if (wr_final)            wr_state_d  = W_RESP;
        end
      end
      W_RESP: begin
        s_bvalid = 1'b1;
        if (s_bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  assign s_bid   = awid_q;
  assign s_bresp = wdec_q ? DECERR : ((wcfg_err_q || wlast_err_q) ? SLVERR : OKAY);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_wstrb[b]) mem[wr_idx][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read FSM
  always_comb begin
    rd_state_d = rd_state_q;
    arid_d     = arid_q;
    raddr_d    = raddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    arburst_d  = arburst_q;
    rcnt_d     = rcnt_q;
    rcfg_err_d = rcfg_err_q;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rlast    = 1'b0;
    s_rresp    = OKAY;
    s_rdata    = '0;

    case (rd_state_q)
      R_IDLE: begin
        s_arready = 1'b1;
        if (s_arvalid) begin
          arid_d     = s_arid;
          raddr_d    = s_araddr;
          arlen_d    = s_arlen;
          arsize_d   = s_arsize;
          arburst_d  = s_arburst;
          rcnt_d     = 8'd0;
          rcfg_err_d = burst_cfg_err(s_arsize, MAX_SIZE, s_arburst, s_arlen);
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        // Outputs depend only on registered address/count, so they hold during stalls
        s_rvalid = 1'b1;
        s_rlast  = rd_final;
        s_rresp  = !rd_in_range ? DECERR : (rcfg_err_q ? SLVERR : OKAY);
        s_rdata  = (rcfg_err_q || !rd_in_range) ? '0 : mem[rd_idx];
        if (s_rready) begin
          raddr_d = raddr_next;
          rcnt_d  = rcnt_q + 8'd1;
          if (rd_final) rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  assign s_rid = arid_q;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q  <= W_IDLE;
      awid_q      <= '0;
      waddr_q     <= '0;
      awlen_q     <= '0;
      awsize_q    <= '0;
      awburst_q   <= '0;
      wcnt_q      <= '0;
      wcfg_err_q  <= 1'b0;
      wlast_err_q <= 1'b0;
      wdec_q      <= 1'b0;
      rd_state_q  <= R_IDLE;
      arid_q      <= '0;
      raddr_q     <= '0;
      arlen_q     <= '0;
      arsize_q    <= '0;
      arburst_q   <= '0;
      rcnt_q      <= '0;
      rcfg_err_q  <= 1'b0;
    end else begin
      wr_state_q  <= wr_state_d;
      awid_q      <= awid_d;
      waddr_q     <= waddr_d;
      awlen_q     <= awlen_d;
      awsize_q    <= awsize_d;
      awburst_q   <= awburst_d;
      wcnt_q      <= wcnt_d;
      wcfg_err_q  <= wcfg_err_d;
      wlast_err_q <= wlast_err_d;
      wdec_q      <= wdec_d;
      rd_state_q  <= rd_state_d;
      arid_q      <= arid_d;
      raddr_q     <= raddr_d;
      arlen_q     <= arlen_d;
      arsize_q    <= arsize_d;
      arburst_q   <= arburst_d;
      rcnt_q      <= rcnt_d;
      rcfg_err_q  <= rcfg_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_041461_axi_sram_slave.sv
`default_nettype none
// ============================================================================
// tb_ysyx_041461_axi_sram_slave: directed + randomized bench with a byte-level
// memory model; honours AXI_SRAM_RANGE_CHK_EN for the out-of-range case | rev 1.0
// ============================================================================
module tb_ysyx_041461_axi_sram_slave;

  localparam int          DEPTH = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_awready, s_awvalid, s_wready, s_wvalid, s_wlast, s_bready, s_bvalid;
  logic [3:0]  s_awid, s_bid, s_arid, s_rid;
  logic [31:0] s_awaddr, s_araddr;
  logic [7:0]  s_awlen, s_arlen, s_wstrb;
  logic [2:0]  s_awsize, s_arsize;
  logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
  logic [63:0] s_wdata, s_rdata;
  logic        s_arready, s_arvalid, s_rready, s_rvalid, s_rlast;

  ysyx_041461_axi_sram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_awready(s_awready), .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awaddr(s_awaddr),
    .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wready(s_wready), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bready(s_bready), .s_bvalid(s_bvalid), .s_bid(s_bid),
    .s_bresp(s_bresp), .s_arready(s_arready), .s_arvalid(s_arvalid), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rready(s_rready), .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rresp(s_rresp),
    .s_rdata(s_rdata), .s_rlast(s_rlast)
  );

  always #5 clk = ~clk;

  logic [63:0] ref_mem [DEPTH];
  logic [63:0] wbuf [256];
  logic [7:0]  sbuf [256];
  logic [63:0] rd_log [256];
  logic [1:0]  rresp_log [256];
  logic [1:0]  last_bresp;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: AXI address rules in plain arithmetic
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                            input int len, input logic [1:0] burst, input int n);
    longint nb, st, aligned, wsz, lower, a;
    st = longint'({32'b0, start});
    nb = longint'(1) << size;
    aligned = (st / nb) * nb;
    if (n == 0 || burst == 2'b00 || burst == 2'b11) return start;
    a = aligned + n * nb;
    if (burst == 2'b10) begin
      wsz   = nb * (len + 1);
      lower = (st / wsz) * wsz;
      if (a >= lower + wsz) a = a - wsz;
    end
    return a[31:0];
  endfunction

  function automatic logic bad_wrap(input int len, input logic [1:0] burst);
    return (burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15);
  endfunction

  function automatic logic cfg_err(input int size, input int len, input logic [1:0] burst);
    return (size > 3) || (burst == 2'b11) || bad_wrap(len, burst);
  endfunction

  function automatic logic in_rng(input logic [31:0] a);
`ifdef AXI_SRAM_RANGE_CHK_EN
    return (a >= BASE) && (longint'({32'b0, a}) < longint'({32'b0, BASE}) + DEPTH * 8);
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return int'((off >> 3) % DEPTH);
  endfunction

  // ---------------- bus tasks
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst, input int last_at,
                          input string tag);
    logic ok, cerr, lerr, dec, wl;
    logic [31:0] a;
    logic [1:0] exp_resp;
    int t;
    cerr = cfg_err(size, len, burst);
    lerr = 1'b0;
    dec  = 1'b0;
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr;
    s_awlen = 8'(len); s_awsize = 3'(size); s_awburst = burst;
    t = 0;
    do begin
      @(negedge clk); ok = s_awready; @(posedge clk); #1; t++;
    end while (!ok && t < 50);
    chk({tag, "_aw_hs"}, 64'(ok), 64'd1);
    s_awvalid = 1'b0;
    for (int n = 0; n <= len; n++) begin
      repeat ($urandom_range(1)) begin @(posedge clk); #1; end
      wl = (last_at < 0) ? (n == len) : (n == last_at);
      s_wvalid = 1'b1; s_wdata = wbuf[n]; s_wstrb = sbuf[n]; s_wlast = wl;
      t = 0;
      do begin
        @(negedge clk); ok = s_wready; @(posedge clk); #1; t++;
      end while (!ok && t < 50);
      chk({tag, "_w_hs"}, 64'(ok), 64'd1);
      s_wvalid = 1'b0; s_wlast = 1'b0;
      a = beat_addr(addr, size, len, burst, n);
      if (wl != (n == len)) lerr = 1'b1;
      if (!in_rng(a)) dec = 1'b1;
      else if (!cerr)
        for (int b = 0; b < 8; b++)
          if (sbuf[n][b]) ref_mem[widx(a)][b*8 +: 8] = wbuf[n][b*8 +: 8];
    end
    exp_resp = dec ? 2'b11 : ((cerr || lerr) ? 2'b10 : 2'b00);
    ok = 1'b0; t = 0;
    while (!ok && t < 50) begin
      s_bready = (t > 3) || ($urandom_range(2) == 0);
      @(negedge clk);
      chk({tag, "_bvalid"}, 64'(s_bvalid), 64'd1);
      chk({tag, "_bid"}, 64'(s_bid), 64'(id));
      chk({tag, "_bresp"}, 64'(s_bresp), 64'(exp_resp));
      last_bresp = s_bresp;
      ok = s_bready && s_bvalid;
      @(posedge clk); #1; t++;
    end
    chk({tag, "_b_hs"}, 64'(ok), 64'd1);
    s_bready = 1'b0;
    @(negedge clk);
    chk({tag, "_awready_after_b"}, 64'(s_awready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input logic [1:0] burst, input int stall_pct,
                         input string tag);
    logic ok, cerr, done, dchk;
    logic [31:0] a;
    logic [63:0] exp_data;
    logic [1:0] exp_resp;
    int t, stalls;
    cerr = cfg_err(size, len, burst);
    dchk = !((burst == 2'b11) || bad_wrap(len, burst));
    s_arvalid = 1'b1; s_arid = id; s_araddr = addr;
    s_arlen = 8'(len); s_arsize = 3'(size); s_arburst = burst;
    t = 0;
    do begin
      @(negedge clk); ok = s_arready; @(posedge clk); #1; t++;
    end while (!ok && t < 50);
    chk({tag, "_ar_hs"}, 64'(ok), 64'd1);
    s_arvalid = 1'b0;
    for (int n = 0; n <= len; n++) begin
      a = beat_addr(addr, size, len, burst, n);
      exp_data = (cerr || !in_rng(a)) ? 64'd0 : ref_mem[widx(a)];
      exp_resp = !in_rng(a) ? 2'b11 : (cerr ? 2'b10 : 2'b00);
      stalls = 0; done = 1'b0;
      while (!done) begin
        s_rready = (stalls >= 6) || ($urandom_range(99) >= stall_pct);
        @(negedge clk);
        chk({tag, "_rvalid"}, 64'(s_rvalid), 64'd1);
        chk({tag, "_rid"}, 64'(s_rid), 64'(id));
        chk({tag, "_rresp"}, 64'(s_rresp), 64'(exp_resp));
        chk({tag, "_rlast"}, 64'(s_rlast), 64'(n == len));
        if (dchk) chk({tag, "_rdata"}, s_rdata, exp_data);
        rd_log[n] = s_rdata;
        rresp_log[n] = s_rresp;
        done = s_rready;
        if (!s_rready) stalls++;
        @(posedge clk); #1;
      end
    end
    s_rready = 1'b0;
    @(negedge clk);
    chk({tag, "_rvalid_end"}, 64'(s_rvalid), 64'd0);
    chk({tag, "_arready_end"}, 64'(s_arready), 64'd1);
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence followed by random traffic
  initial begin
    logic [1:0]  bt;
    int          sz, ln;
    logic [31:0] ad;
    s_awvalid = 0; s_awid = 0; s_awaddr = 0; s_awlen = 0; s_awsize = 0; s_awburst = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 0;
    s_arvalid = 0; s_arid = 0; s_araddr = 0; s_arlen = 0; s_arsize = 0; s_arburst = 0;
    s_rready = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_awready", 64'(s_awready), 64'd1);
    chk("rst_arready", 64'(s_arready), 64'd1);
    chk("rst_bvalid", 64'(s_bvalid), 64'd0);
    chk("rst_rvalid", 64'(s_rvalid), 64'd0);
    chk("rst_rlast", 64'(s_rlast), 64'd0);
    chk("rst_rdata", s_rdata, 64'd0);
    chk("rst_bresp", 64'(s_bresp), 64'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 64; n++) begin
      wbuf[n] = {$urandom, $urandom}; sbuf[n] = 8'hFF;
    end
    do_write(4'h1, BASE, 63, 3, 2'b01, -1, "init");

    wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33; wbuf[3] = 64'h44;
    for (int n = 0; n < 4; n++) sbuf[n] = 8'hFF;
    do_write(4'h5, BASE, 3, 3, 2'b01, -1, "incr_wr");
    chk("incr_bresp_okay", 64'(last_bresp), 64'd0);
    do_read(4'hA, BASE, 3, 3, 2'b01, 0, "incr_rd");
    chk("incr_b0", rd_log[0], 64'h11);
    chk("incr_b3", rd_log[3], 64'h44);

    do_read(4'h3, BASE + 32'h18, 3, 3, 2'b10, 0, "wrap_rd");
    chk("wrap_b0", rd_log[0], 64'h44);
    chk("wrap_b1", rd_log[1], 64'h11);
    chk("wrap_b2", rd_log[2], 64'h22);
    chk("wrap_b3", rd_log[3], 64'h33);

    wbuf[0] = 64'h0000_0000_AB00_0000; sbuf[0] = 8'h08;
    do_write(4'h2, BASE + 32'h3, 0, 0, 2'b01, -1, "narrow_wr");
    do_read(4'h2, BASE, 0, 3, 2'b01, 0, "narrow_rd");
    chk("narrow_word0", rd_log[0], 64'h0000_0000_AB00_0011);

    for (int n = 0; n < 4; n++) begin wbuf[n] = {$urandom, $urandom}; sbuf[n] = 8'hFF; end
    do_write(4'h6, BASE + 32'h40, 3, 3, 2'b01, 1, "early_wlast");
    chk("early_wlast_slverr", 64'(last_bresp), 64'd2);
    do_read(4'h6, BASE + 32'h40, 3, 3, 2'b01, 40, "early_wlast_rd");

    for (int n = 0; n < 2; n++) begin wbuf[n] = {$urandom, $urandom}; sbuf[n] = 8'hFF; end
    do_write(4'h7, BASE + 32'h80, 1, 4, 2'b01, -1, "oversize_wr");
    chk("oversize_slverr", 64'(last_bresp), 64'd2);
    do_read(4'h7, BASE + 32'h80, 3, 3, 2'b01, 0, "after_oversize");
    do_read(4'h7, BASE + 32'h80, 1, 4, 2'b01, 0, "oversize_rd");

    do_read(4'h8, BASE, 2, 3, 2'b11, 0, "rsvd_rd");
    do_read(4'h9, BASE, 2, 3, 2'b10, 0, "badwrap_rd");

    do_read(4'hC, BASE + 32'(DEPTH * 8), 0, 3, 2'b01, 0, "oor_rd");
`ifdef AXI_SRAM_RANGE_CHK_EN
    chk("oor_decerr", 64'(rresp_log[0]), 64'd3);
    chk("oor_zero", rd_log[0], 64'd0);
`else
    chk("oor_okay", 64'(rresp_log[0]), 64'd0);
    chk("oor_word0", rd_log[0], ref_mem[0]);
`endif

    for (int it = 0; it < 24; it++) begin
      bt = 2'($urandom_range(2));
      sz = $urandom_range(3);
      if (bt == 2'b10) ln = (2 << $urandom_range(3)) - 1;
      else             ln = $urandom_range(15);
      ad = BASE + 32'($urandom_range(255));
      if (bt == 2'b10) ad = ad & ~((32'd1 << sz) - 32'd1);
      for (int n = 0; n <= ln; n++) begin
        wbuf[n] = {$urandom, $urandom}; sbuf[n] = 8'($urandom);
      end
      do_write(4'(it), ad, ln, sz, bt, -1, "rnd_wr");
      do_read(4'(it + 1), ad, ln, sz, bt, 35, "rnd_rd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
